// File: rtl/circ_shift_reg_param.sv
// Parametrised circular/logical shift register with parallel load.
// Counts shifts modulo WIDTH and pulses wrap at each completed period.
module circ_shift_reg_param #(
    parameter int WIDTH = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     load,
    input  logic [WIDTH-1:0]         load_in,
    input  logic                     shift_en,
    input  logic                     dir,
    input  logic                     mode,
    input  logic                     serial_in,
    output logic [WIDTH-1:0]         q,
    output logic                     shift_out,
    output logic [$clog2(WIDTH)-1:0] count,
    output logic                     wrap
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > 64) begin : g_width_check
        $error("circ_shift_reg_param: WIDTH must be 2..64");
    end

    logic [WIDTH-1:0] q_next;
    logic             fill_right;
    logic             fill_left;
    logic             at_last;

    // Logical mode fills from serial_in; rotate mode recirculates the exiting bit.
    always_comb begin
        fill_right = mode ? serial_in : q[0];
        fill_left  = mode ? serial_in : q[WIDTH-1];
        if (dir) begin
            q_next = {q[WIDTH-2:0], fill_left};
        end else begin
            q_next = {fill_right, q[WIDTH-1:1]};
        end
    end

    assign at_last = (count == LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q     <= RESET_VALUE;
            count <= '0;
            wrap  <= 1'b0;
        end else if (load) begin
            q     <= load_in;
            count <= '0;
            wrap  <= 1'b0;
        end else if (shift_en) begin
            q     <= q_next;
            count <= at_last ? '0 : count + CW'(1);
            wrap  <= at_last;
        end else begin
            wrap  <= 1'b0;
        end
    end

    assign shift_out = dir ? q[WIDTH-1] : q[0];

endmodule

// File: tb/tb_circ_shift_reg_param.sv
// Bench for circ_shift_reg_param: arithmetic reference model checked every
// cycle on WIDTH=16 and WIDTH=5 instances, plus directed literal checks.
module tb_circ_shift_reg_param;

    localparam logic [15:0] RV16 = 16'h00F0;

    logic clock = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    logic        a_load = 0, a_shift = 0, a_dir = 0, a_mode = 0, a_si = 0;
    logic [15:0] a_din = '0;
    logic [15:0] a_q;
    logic        a_so, a_wrap;
    logic [3:0]  a_count;

    logic        b_load = 0, b_shift = 0, b_dir = 0, b_mode = 0, b_si = 0;
    logic [4:0]  b_din = '0;
    logic [4:0]  b_q;
    logic        b_so, b_wrap;
    logic [2:0]  b_count;

    circ_shift_reg_param #(.WIDTH(16), .RESET_VALUE(RV16)) u16 (
        .clock(clock), .reset_n(reset_n), .load(a_load), .load_in(a_din),
        .shift_en(a_shift), .dir(a_dir), .mode(a_mode), .serial_in(a_si),
        .q(a_q), .shift_out(a_so), .count(a_count), .wrap(a_wrap)
    );

    circ_shift_reg_param #(.WIDTH(5)) u5 (
        .clock(clock), .reset_n(reset_n), .load(b_load), .load_in(b_din),
        .shift_en(b_shift), .dir(b_dir), .mode(b_mode), .serial_in(b_si),
        .q(b_q), .shift_out(b_so), .count(b_count), .wrap(b_wrap)
    );

    int nvec = 0;
    int nerr = 0;
    bit chk_on = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference shift on a w-bit value held in a 64-bit word.
    function automatic logic [63:0] nxt(input logic [63:0] v, input int w,
                                        input logic d, input logic m, input logic s);
        logic [63:0] mask;
        logic        fill;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        if (!d) begin
            fill = m ? s : v[0];
            return (v >> 1) | ({63'd0, fill} << (w - 1));
        end
        fill = m ? s : v[w-1];
        return ((v << 1) & mask) | {63'd0, fill};
    endfunction

    logic [63:0] ma_q = 64'(RV16);
    int          ma_sh = 0;
    bit          ma_w = 0;
    logic [63:0] mb_q = '0;
    int          mb_sh = 0;
    bit          mb_w = 0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ma_q = 64'(RV16); ma_sh = 0; ma_w = 0;
        end else if (a_load) begin
            ma_q = 64'(a_din); ma_sh = 0; ma_w = 0;
        end else if (a_shift) begin
            ma_q = nxt(ma_q, 16, a_dir, a_mode, a_si);
            ma_sh++;
            ma_w = (ma_sh % 16 == 0);
        end else begin
            ma_w = 0;
        end
    end

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mb_q = '0; mb_sh = 0; mb_w = 0;
        end else if (b_load) begin
            mb_q = 64'(b_din); mb_sh = 0; mb_w = 0;
        end else if (b_shift) begin
            mb_q = nxt(mb_q, 5, b_dir, b_mode, b_si);
            mb_sh++;
            mb_w = (mb_sh % 5 == 0);
        end else begin
            mb_w = 0;
        end
    end

    always @(negedge clock) begin
        if (chk_on) begin
            chk("a_q", 64'(a_q), ma_q);
            chk("a_count", 64'(a_count), 64'(ma_sh % 16));
            chk("a_wrap", 64'(a_wrap), 64'(ma_w));
            chk("a_so", 64'(a_so), 64'(a_dir ? ma_q[15] : ma_q[0]));
            chk("b_q", 64'(b_q), mb_q);
            chk("b_count", 64'(b_count), 64'(mb_sh % 5));
            chk("b_wrap", 64'(b_wrap), 64'(mb_w));
            chk("b_so", 64'(b_so), 64'(b_dir ? mb_q[4] : mb_q[0]));
        end
    end

    task automatic cyc_a(input logic ld, input logic [15:0] din, input logic sh,
                         input logic d, input logic m, input logic s);
        a_load = ld; a_din = din; a_shift = sh; a_dir = d; a_mode = m; a_si = s;
        @(negedge clock);
        #1;
    endtask

    task automatic cyc_b(input logic ld, input logic [4:0] din, input logic sh);
        b_load = ld; b_din = din; b_shift = sh; b_dir = 0; b_mode = 0; b_si = 0;
        @(negedge clock);
        #1;
    endtask

    initial begin
        #1 reset_n = 0;
        chk_on = 1;
        @(negedge clock); #1;
        chk("reset_q", 64'(a_q), 64'h00F0);
        chk("reset_count", 64'(a_count), 64'd0);
        reset_n = 1;

        // Rotate right 0xAAAA: shift_out toggles every clock, wrap after 16.
        cyc_a(1, 16'hAAAA, 0, 0, 0, 0);
        chk("load_aaaa", 64'(a_q), 64'hAAAA);
        for (int i = 1; i <= 16; i++) begin
            cyc_a(0, 0, 1, 0, 0, 0);
            chk("aaaa_so", 64'(a_so), 64'(i % 2));
            chk("aaaa_wrap", 64'(a_wrap), 64'(i == 16));
            if (i == 1) chk("aaaa_1", 64'(a_q), 64'h5555);
        end
        chk("aaaa_back", 64'(a_q), 64'hAAAA);
        chk("aaaa_cnt", 64'(a_count), 64'd0);
        cyc_a(0, 0, 0, 0, 0, 0);
        chk("wrap_one_cycle", 64'(a_wrap), 64'd0);

        // 0xCCCC rotate right: shift_out period of 4 clocks.
        cyc_a(1, 16'hCCCC, 0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            cyc_a(0, 0, 1, 0, 0, 0);
            chk("cccc_so", 64'(a_so), 64'((i % 4) >= 2));
        end

        // Rotate left 0x8001 -> 0x0003; also flip dir between edges.
        cyc_a(1, 16'h8001, 0, 1, 0, 0);
        chk("so_dir_left", 64'(a_so), 64'd1);
        cyc_a(0, 0, 1, 1, 0, 0);
        chk("rotl_8001", 64'(a_q), 64'h0003);
        cyc_a(0, 0, 0, 0, 0, 0);
        chk("so_dir_right", 64'(a_so), 64'd1);

        // Logical right, serial_in=1, from zero.
        cyc_a(1, 16'h0000, 0, 0, 1, 1);
        for (int i = 1; i <= 16; i++) begin
            cyc_a(0, 0, 1, 0, 1, 1);
            if (i == 4) chk("lsr_4", 64'(a_q), 64'hF000);
            if (i == 15) chk("lsr_wrap15", 64'(a_wrap), 64'd0);
        end
        chk("lsr_16", 64'(a_q), 64'hFFFF);
        chk("lsr_wrap16", 64'(a_wrap), 64'd1);

        // Load beats shift, including at count==15.
        cyc_a(1, 16'h1234, 1, 0, 0, 0);
        chk("ld_sh_q", 64'(a_q), 64'h1234);
        chk("ld_sh_cnt", 64'(a_count), 64'd0);
        for (int i = 0; i < 15; i++) cyc_a(0, 0, 1, 1, 0, 0);
        chk("cnt15", 64'(a_count), 64'd15);
        cyc_a(1, 16'h2222, 1, 1, 0, 0);
        chk("ld15_wrap", 64'(a_wrap), 64'd0);
        chk("ld15_cnt", 64'(a_count), 64'd0);
        chk("ld15_q", 64'(a_q), 64'h2222);

        // Asynchronous reset mid-period.
        cyc_a(1, 16'hAAAA, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) cyc_a(0, 0, 1, 0, 0, 0);
        chk("pre_rst_cnt", 64'(a_count), 64'd7);
        #1 reset_n = 0;
        #1;
        chk("arst_q", 64'(a_q), 64'h00F0);
        chk("arst_cnt", 64'(a_count), 64'd0);
        chk("arst_wrap", 64'(a_wrap), 64'd0);
        cyc_a(1, 16'h5A5A, 1, 0, 0, 0);
        chk("rst_hold_q", 64'(a_q), 64'h00F0);
        reset_n = 1;
        cyc_a(1, 16'h5A5A, 0, 0, 0, 0);
        chk("post_rst_ld", 64'(a_q), 64'h5A5A);
        cyc_a(0, 0, 0, 0, 0, 0);

        // WIDTH=5 with gapped shift_en.
        cyc_b(1, 5'b10110, 0);
        for (int i = 1; i <= 20; i++) begin
            cyc_b(0, 0, (i % 2) == 1);
            chk("w5_wrap", 64'(b_wrap), 64'((i % 2 == 1) && (((i + 1) / 2) % 5 == 0)));
            chk("w5_cnt", 64'(b_count), 64'(((i + 1) / 2) % 5));
            if (b_wrap) chk("w5_q_at_wrap", 64'(b_q), 64'h16);
        end
        cyc_b(0, 0, 0);

        chk_on = 0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/circ_shift_reg_param.md
# circ_shift_reg_param

Parametrised circular/logical shift register with parallel load, selectable shift direction and mode, and a shift-period counter with a wrap pulse. It replaces the fixed 16-bit circular shift register as the pattern-based frequency/waveform generator: loading a bit pattern and rotating it produces a periodic serial stream on `shift_out`. The `wrap` pulse marks each completed pattern period for downstream logic.

## Interface
- `WIDTH`, 16: register width in bits; legal range 2..64.
- `RESET_VALUE`, {WIDTH{1'b0}}: value of `q` after reset.

- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `load`  in  1  parallel load strobe; highest priority.
- `load_in`  in  WIDTH  parallel load data.
- `shift_en`  in  1  perform one shift this cycle.
- `dir`  in  1  0 = shift right (toward bit 0), 1 = shift left (toward bit WIDTH-1).
- `mode`  in  1  0 = rotate (circular), 1 = logical shift with `serial_in` fill.
- `serial_in`  in  1  fill bit in logical mode.
- `q`  out  WIDTH  register contents.
- `shift_out`  out  1  output-end bit: `q[0]` when `dir`=0, `q[WIDTH-1]` when `dir`=1.
- `count`  out  $clog2(WIDTH)  shifts performed since the last load/reset, modulo WIDTH.
- `wrap`  out  1  one-cycle pulse marking a completed period of WIDTH shifts.

## Operation
- Reset (`reset_n`=0, asynchronous): `q`=RESET_VALUE, `count`=0, `wrap`=0. These values hold while `reset_n` is low, regardless of the other inputs.
- Per rising edge, priority order: `load`, then `shift_en`, then hold.
- `load`=1: `q`<=`load_in`, `count`<=0, `wrap`<=0. `shift_en` is ignored that cycle.
- `shift_en`=1, `load`=0:
  - `dir`=0, `mode`=0: `q`<={q[0], q[WIDTH-1:1]}.
  - `dir`=0, `mode`=1: `q`<={serial_in, q[WIDTH-1:1]}.
  - `dir`=1, `mode`=0: `q`<={q[WIDTH-2:0], q[WIDTH-1]}.
  - `dir`=1, `mode`=1: `q`<={q[WIDTH-2:0], serial_in}.
  - `count`<=(count==WIDTH-1) ? 0 : count+1. The counter wraps at WIDTH, not at 2^bits, for non-power-of-two WIDTH.
  - `wrap`<=1 only when `count`==WIDTH-1 on this shift, else 0.
- Hold (neither strobe): `q` and `count` keep their values; `wrap`<=0.
- `dir` and `mode` may change on any cycle. Only their values at the shifting edge matter, and `count` is unaffected by such changes.
- `shift_out` is a combinational mux of `q` by the current `dir`. It has no extra register.

## Timing
- `q`, `count` and `wrap` are registered, with one-cycle latency from strobe to output.
- In rotate mode with continuous `shift_en`, `q` returns to its loaded value exactly WIDTH edges after the load. `wrap` is high in the cycle following the WIDTH-th shift edge, which is also the cycle in which `q` equals the loaded value again.
- With `shift_en` gapped, `wrap` asserts after the WIDTH-th actual shift, not after WIDTH clock cycles.
- Simultaneous `load` and a `count`==WIDTH-1 shift: the load wins, `count`=0 and `wrap`=0.
- Reset asserted mid-period: outputs go to reset values immediately, asynchronously. After `reset_n` rises, the first rising edge with a strobe acts normally.
- `shift_out` settles combinationally after a `q` change or a `dir` change.

## Test plan
- WIDTH=16, load 0xAAAA, rotate right, `shift_en`=1 continuously: `shift_out` toggles every clock (frequency clock/2). `q` alternates 0x5555/0xAAAA. `wrap` pulses every 16 cycles, `count` runs 0..15.
- WIDTH=16, load 0xCCCC, rotate right: `shift_out` period is 4 clocks (0,0,1,1 ...). Rotate left from 0x8001 gives 0x0003 after one shift.
- Logical right, `serial_in`=1, load 0x0000: after 16 shifts `q`=0xFFFF, with intermediate value 0xF000 after 4 shifts. `wrap` asserts after the 16th shift.
- Simultaneous events: `load`=1 and `shift_en`=1 with `load_in`=0x1234 gives `q`=0x1234, `count`=0. `load` asserted while `count`=15 with `shift_en` gives no `wrap`.
- Reset mid-operation: after 7 shifts of 0xAAAA, drop `reset_n` between edges. `q`=RESET_VALUE, `count`=0 and `wrap`=0 immediately, with no clock edge needed. After release, the next load is accepted on the first edge.
- WIDTH=5, rotate with `shift_en` toggling every other cycle: `count` goes 0..4 then back to 0, `wrap` pulses after every 5th shift (every 10 clocks), and `q` equals the loaded value at each `wrap`.
